f_npc: RTL and testbench
========================

Name: f_npc

Overview:
- Fetch-stage PC register and next-PC selector. It consumes the branch/jump targets produced by the D-stage immediate extender, and register-jump targets from D-stage rs.
- Redirects the PC on exception entry (handler) and eret (EPC from CP0).
- Flags fetch address errors (AdEL) and the delay-slot status of the F-stage instruction.
- Sits between CP0 / D-stage control and IM/F-D pipeline register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; hold PC.
- d_npcSel  in  2  00 seq, 01 branch, 10 j/jal, 11 jr/jalr.
- d_brTaken  in  1  D-stage comparator result; used only when d_npcSel=01.
- d_target  in  32  extender output: pc+4+offset<<2 (branch) or {pc[31:28],imm26,00} (j).
- d_rsData  in  32  forwarded rs value for jr/jalr.
- req  in  1  CP0 exception/interrupt request.
- eret  in  1  eret in D stage.
- epc  in  32  CP0 EPC (forwarded).
- f_pc  out  32  current fetch address to IM.
- f_bd  out  1  F-stage instruction is in a delay slot.
- f_excAdEL  out  1  fetch address error for f_pc.

Behaviour:
- f_pc is a register.
  - On reset: f_pc=RESET_PC.
  - Outputs after reset: f_bd=0 (while d_npcSel=00), f_excAdEL=0.
- Next-PC priority, evaluated on every rising edge:
  - 1) reset -> RESET_PC.
  - 2) req -> HANDLER_PC. Ignores stall, eret and d_npcSel.
  - 3) eret -> epc. Ignores stall. No delay slot; the following F instruction is flushed outside this block.
  - 4) stall -> hold f_pc.
  - 5) d_npcSel=01 and d_brTaken -> d_target.
  - 6) d_npcSel=10 -> d_target.
  - 7) d_npcSel=11 -> d_rsData, taken unmodified even when misaligned.
  - 8) otherwise -> f_pc+4, 32-bit wrap with no carry out (32'hFFFF_FFFC+4 = 0).
- Latency: one cycle from control inputs to f_pc.
- Branch semantics:
  - Branch not taken (01, d_brTaken=0) -> f_pc+4.
  - The delay slot is the instruction currently at f_pc, so the target fetch follows it with no bubble.
- f_bd (combinational): 1 when d_npcSel != 00, regardless of d_brTaken; 0 otherwise. It is the value the F-D register latches as the BD bit.
- f_excAdEL (combinational from the f_pc register): 1 if either
  - f_pc[1:0] != 0, or
  - f_pc < IM_LO, or
  - f_pc > IM_HI (unsigned compares).
- The bad PC is still presented on f_pc; the F stage substitutes a nop and carries AdEL with EPC=f_pc.
- Simultaneous events:
  - req+eret -> handler.
  - req+stall -> handler.
  - eret+stall -> epc.
- Reset asserted during any redirect -> RESET_PC wins. Nothing is pending internally across reset.

Optional Feature:
- NPC_RANGE_CHECK_EN.
  - Defined: f_excAdEL includes the IM_LO/IM_HI range checks.
  - Undefined: f_excAdEL = (f_pc[1:0] != 0) only; IM_LO/IM_HI are unused.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles, release -> f_pc=0x3000, 0x3004, 0x3008 on successive edges; f_excAdEL=0.
- Taken branch:
  - Stimulus: f_pc=0x3010, d_npcSel=01, d_brTaken=1, d_target=0x3100.
  - Response: f_bd=1 that cycle; next f_pc=0x3100.
  - Same stimulus with d_brTaken=0 -> f_pc=0x3014, f_bd=1.
- Stall vs jump:
  - Stimulus: stall=1, d_npcSel=10, d_target=0x3200 at f_pc=0x3020.
  - Response: f_pc stays 0x3020; then stall=0 -> f_pc=0x3200.
- Exception priority:
  - Stimulus: req=1, eret=1, stall=1, d_npcSel=11 at f_pc=0x3040.
  - Response: f_pc=0x4180.
  - Next cycle eret=1, epc=0x3044, req=0 -> f_pc=0x3044.
- jr misaligned: d_npcSel=11, d_rsData=0x3006 -> f_pc=0x3006, f_excAdEL=1.
- Range check:
  - Stimulus: jr to 0x7000.
  - Response: f_excAdEL=1 with NPC_RANGE_CHECK_EN defined; f_excAdEL=0 without it.
  - jr to 0x6FFC -> f_excAdEL=0 in both builds.

Source files
------------

// File: rtl/f_npc.sv
// Fetch-stage PC register and next-PC selector (exception, eret, stall, branch/jump/jr).
// Optional macro NPC_RANGE_CHECK_EN: adds IM_LO/IM_HI bounds to the fetch address error.
module f_npc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  d_npcSel,
  input  logic        d_brTaken,
  input  logic [31:0] d_target,
  input  logic [31:0] d_rsData,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] f_pc,
  output logic        f_bd,
  output logic        f_excAdEL
);

  localparam logic [1:0] SEL_BR = 2'b01;
  localparam logic [1:0] SEL_J  = 2'b10;
  localparam logic [1:0] SEL_JR = 2'b11;

`ifdef NPC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic [31:0] pc_nxt;
  logic        misaligned;
  logic        out_of_range;

  // Redirect priority: exception entry, then eret, then stall, then D-stage control flow.
  always_comb begin
    pc_nxt = f_pc + 32'd4;
    if (req)
      pc_nxt = HANDLER_PC;
    else if (eret)
      pc_nxt = epc;
    else if (stall)
      pc_nxt = f_pc;
    else begin
      case (d_npcSel)
        SEL_BR:  if (d_brTaken) pc_nxt = d_target;
        SEL_J:   pc_nxt = d_target;
        SEL_JR:  pc_nxt = d_rsData;
        default: pc_nxt = f_pc + 32'd4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      f_pc <= RESET_PC;
    else
      f_pc <= pc_nxt;
  end

  // The F instruction sits in a delay slot whenever D holds any control transfer, taken or not.
  assign f_bd = (d_npcSel != 2'b00);

  assign misaligned   = (f_pc[1:0] != 2'b00);
  assign out_of_range = (f_pc < IM_LO) || (f_pc > IM_HI);
  assign f_excAdEL    = misaligned || (RANGE_EN && out_of_range);

endmodule

// File: tb/tb_f_npc.sv
// Self-checking bench for f_npc: directed test-plan sequence followed by randomized cycles.
module tb_f_npc;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HND_PC  = 32'h0000_4180;
  localparam logic [31:0] LO      = 32'h0000_3000;
  localparam logic [31:0] HI      = 32'h0000_6FFC;
`ifdef NPC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, d_brTaken, req, eret;
  logic [1:0]  d_npcSel;
  logic [31:0] d_target, d_rsData, epc;
  logic [31:0] f_pc;
  logic        f_bd, f_excAdEL;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  f_npc dut (
    .clk(clk), .reset(reset), .stall(stall), .d_npcSel(d_npcSel),
    .d_brTaken(d_brTaken), .d_target(d_target), .d_rsData(d_rsData),
    .req(req), .eret(eret), .epc(epc),
    .f_pc(f_pc), .f_bd(f_bd), .f_excAdEL(f_excAdEL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (RANGE_EN && (pc < LO || pc > HI));
  endfunction

  // One clock: apply inputs, check combinational outputs, clock, check the new PC.
  task automatic cyc(input logic rst, input logic st, input logic [1:0] sel, input logic br,
                     input logic [31:0] tgt, input logic [31:0] rs,
                     input logic rq, input logic er, input logic [31:0] ep);
    logic [31:0] nxt;
    reset = rst; stall = st; d_npcSel = sel; d_brTaken = br;
    d_target = tgt; d_rsData = rs; req = rq; eret = er; epc = ep;
    #2;
    chk("f_bd", {31'b0, f_bd}, {31'b0, sel != 2'b00});
    if (m_valid) chk("f_excAdEL", {31'b0, f_excAdEL}, {31'b0, exp_adel(m_pc)});
    if (rst)                          nxt = RST_PC;
    else if (rq)                      nxt = HND_PC;
    else if (er)                      nxt = ep;
    else if (st)                      nxt = m_pc;
    else if (sel == 2'd2 || (sel == 2'd1 && br)) nxt = tgt;
    else if (sel == 2'd3)             nxt = rs;
    else                              nxt = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (rst || m_valid) begin
      m_pc = nxt;
      m_valid = 1'b1;
      chk("f_pc", f_pc, m_pc);
    end
  endtask

  task automatic seq();
    cyc(0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic jr(input logic [31:0] a);
    cyc(0, 0, 2'd3, 0, 32'h0, a, 0, 0, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = $urandom;
    else a = LO + ($urandom_range(0, 32'h1000) << 2);
    if ($urandom_range(0, 7) == 0) a = a + ($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    reset = 1'b1; stall = 0; d_npcSel = 0; d_brTaken = 0;
    d_target = 0; d_rsData = 0; req = 0; eret = 0; epc = 0;
    @(negedge clk);

    cyc(1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("reset_pc", f_pc, 32'h3000);
    seq(); chk("seq1", f_pc, 32'h3004);
    seq(); chk("seq2", f_pc, 32'h3008);
    seq(); seq(); chk("at_3010", f_pc, 32'h3010);
    cyc(0, 0, 2'd1, 1, 32'h3100, 32'h0, 0, 0, 32'h0);
    chk("br_taken", f_pc, 32'h3100);
    jr(32'h3010);
    cyc(0, 0, 2'd1, 0, 32'h3100, 32'h0, 0, 0, 32'h0);
    chk("br_not_taken", f_pc, 32'h3014);
    jr(32'h3020);
    cyc(0, 1, 2'd2, 0, 32'h3200, 32'h0, 0, 0, 32'h0);
    chk("stall_hold", f_pc, 32'h3020);
    cyc(0, 0, 2'd2, 0, 32'h3200, 32'h0, 0, 0, 32'h0);
    chk("jump", f_pc, 32'h3200);
    jr(32'h3040);
    cyc(0, 1, 2'd3, 0, 32'h0, 32'h5000, 1, 1, 32'h3044);
    chk("req_prio", f_pc, 32'h4180);
    cyc(0, 1, 2'd2, 0, 32'h5000, 32'h0, 0, 1, 32'h3044);
    chk("eret_over_stall", f_pc, 32'h3044);
    jr(32'h3006);
    chk("jr_misaligned", f_pc, 32'h3006);
    #1 chk("adel_misaligned", {31'b0, f_excAdEL}, 32'd1);
    jr(32'h7000);
    #1 chk("adel_7000", {31'b0, f_excAdEL}, {31'b0, RANGE_EN});
    jr(32'h6FFC);
    #1 chk("adel_6ffc", {31'b0, f_excAdEL}, 32'd0);
    jr(32'hFFFF_FFFC);
    seq(); chk("wrap", f_pc, 32'h0);
    cyc(1, 1, 2'd3, 0, 32'h0, 32'h5000, 1, 1, 32'h3044);
    chk("reset_wins", f_pc, 32'h3000);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(),
          $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0, rnd_addr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
